// File: rtl/multi_row_camera_ctrl_if.sv
// Control and status bundle between a frame sequencer (master) and the camera controller (slave).
// The _i/_o suffixes are named from the controller's point of view.
interface multi_row_camera_ctrl_if #(
   parameter int NUM_ROWS = 2,
   parameter int EXP_W    = 5
);
   logic                init_i;
   logic                expInc_i;
   logic                expDec_i;
   logic                continuous_i;
   logic [NUM_ROWS-1:0] nre_o;
   logic                adc_o;
   logic                expose_o;
   logic                erase_o;
   logic                busy_o;
   logic                frameDone_o;
   logic [EXP_W-1:0]    expTime_o;

   modport master (
      output init_i, expInc_i, expDec_i, continuous_i,
      input  nre_o, adc_o, expose_o, erase_o, busy_o, frameDone_o, expTime_o
   );

   modport slave (
      input  init_i, expInc_i, expDec_i, continuous_i,
      output nre_o, adc_o, expose_o, erase_o, busy_o, frameDone_o, expTime_o
   );
endinterface

// File: rtl/multi_row_camera_ctrl.sv
// Multi-row camera sequencer: erase, expose, then read each amplifier row with an optional gap.
// Every output is registered and reflects the state entered on the same clock edge.
module multi_row_camera_ctrl #(
   parameter int NUM_ROWS   = 2,
   parameter int EXP_W      = 5,
   parameter int EXP_MIN    = 2,
   parameter int EXP_MAX    = 30,
   parameter int EXP_RESET  = 15,
   parameter int ADC_CYCLES = 5,
   parameter int GAP_CYCLES = 1
) (
   input logic                    clk,
   input logic                    reset,
   multi_row_camera_ctrl_if.slave bus
);

   localparam int CNT_MAX_A = (EXP_MAX > ADC_CYCLES) ? EXP_MAX : ADC_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

   localparam logic [EXP_W-1:0] EXP_MIN_V   = EXP_W'(EXP_MIN);
   localparam logic [EXP_W-1:0] EXP_MAX_V   = EXP_W'(EXP_MAX);
   localparam logic [EXP_W-1:0] EXP_RESET_V = EXP_W'(EXP_RESET);
   localparam logic [CNT_W-1:0] ADC_LAST    = CNT_W'(ADC_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(NUM_ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      EXPOSE,
      READ,
      GAP,
      DONE
   } state_e;

   state_e              state_q,     state_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic [ROW_W-1:0]    row_q,       row_d;
   logic [EXP_W-1:0]    expTime_q,   expTime_d;
   logic [EXP_W-1:0]    expLat_q,    expLat_d;
   logic [NUM_ROWS-1:0] nre_q,       nre_d;
   logic                adc_q,       adc_d;
   logic                expose_q,    expose_d;
   logic                erase_q,     erase_d;
   logic                busy_q,      busy_d;
   logic                frameDone_q, frameDone_d;
   logic [CNT_W-1:0]    exposeLast;

   // The cycle counter counts 0..duration-1 within each timed state, so the
   // exposure ends when it reaches the latched exposure time minus one.
   assign exposeLast = CNT_W'(expLat_q - EXP_W'(1));

   // Next-state logic; the output values are derived from the state being
   // entered so the registered outputs line up with the state register.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      expTime_d = expTime_q;
      expLat_d  = expLat_q;

      case (state_q)
         IDLE: begin
            if (bus.init_i) begin
               state_d  = EXPOSE;
               cnt_d    = '0;
               row_d    = '0;
               expLat_d = expTime_q;
            end else if (bus.expInc_i && !bus.expDec_i) begin
               if (expTime_q < EXP_MAX_V) begin
                  expTime_d = expTime_q + EXP_W'(1);
               end
            end else if (bus.expDec_i && !bus.expInc_i) begin
               if (expTime_q > EXP_MIN_V) begin
                  expTime_d = expTime_q - EXP_W'(1);
               end
            end
         end

         EXPOSE: begin
            if (cnt_q == exposeLast) begin
               state_d = READ;
               cnt_d   = '0;
               row_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // With no gap configured, rows are read back to back without leaving READ.
         READ: begin
            if (cnt_q == ADC_LAST) begin
               cnt_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
               end else if (row_q == LAST_ROW) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (row_q == LAST_ROW) begin
                  state_d = DONE;
               end else begin
                  state_d = READ;
                  row_d   = row_q + ROW_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            cnt_d = '0;
            row_d = '0;
            if (bus.continuous_i) begin
               state_d  = EXPOSE;
               expLat_d = expTime_q;
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
         end
      endcase

      nre_d = '1;
      for (int i = 0; i < NUM_ROWS; i++) begin
         nre_d[i] = !((state_d == READ) && (row_d == ROW_W'(i)));
      end
      adc_d       = (state_d == READ);
      expose_d    = (state_d == EXPOSE);
      erase_d     = (state_d == IDLE) || (state_d == DONE);
      busy_d      = (state_d != IDLE);
      frameDone_d = (state_d == DONE);
   end

   // State, counters and output registers; reset abandons any frame in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         row_q       <= '0;
         expTime_q   <= EXP_RESET_V;
         expLat_q    <= EXP_RESET_V;
         nre_q       <= '1;
         adc_q       <= 1'b0;
         expose_q    <= 1'b0;
         erase_q     <= 1'b1;
         busy_q      <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         row_q       <= row_d;
         expTime_q   <= expTime_d;
         expLat_q    <= expLat_d;
         nre_q       <= nre_d;
         adc_q       <= adc_d;
         expose_q    <= expose_d;
         erase_q     <= erase_d;
         busy_q      <= busy_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign bus.nre_o       = nre_q;
   assign bus.adc_o       = adc_q;
   assign bus.expose_o    = expose_q;
   assign bus.erase_o     = erase_q;
   assign bus.busy_o      = busy_q;
   assign bus.frameDone_o = frameDone_q;
   assign bus.expTime_o   = expTime_q;

endmodule

// File: doc/multi_row_camera_ctrl.md
MULTI_ROW_CAMERA_CTRL -- requirements
Module: multi_row_camera_ctrl

Interface
REQ-001 Parameter NUM_ROWS, default 2: number of amplifier rows read per frame; range 1..16.
REQ-002 Parameter EXP_W, default 5: width of the exposure-time register.
REQ-003 Parameter EXP_MIN, default 2: lowest exposure time in cycles; must be at least 1.
REQ-004 Parameter EXP_MAX, default 30: highest exposure time; EXP_MIN <= EXP_MAX < 2**EXP_W.
REQ-005 Parameter EXP_RESET, default 15: exposure time after reset; EXP_MIN..EXP_MAX.
REQ-006 Parameter ADC_CYCLES, default 5: cycles each row is read; must be at least 1.
REQ-007 Parameter GAP_CYCLES, default 1: idle cycles after each row read; range 0..15.
REQ-008 clk  in  1  clock; all logic is on the rising edge.
REQ-009 reset  in  1  synchronous, active-low reset.
REQ-010 init  in  1  start a frame; sampled in IDLE only.
REQ-011 exp_inc  in  1  increase exposure by 1 per cycle held; sampled in IDLE only.
REQ-012 exp_dec  in  1  decrease exposure by 1 per cycle held; sampled in IDLE only.
REQ-013 continuous  in  1  when 1, a frame restarts automatically after DONE.
REQ-014 nre  out  NUM_ROWS  active-low row read enables.
REQ-015 adc  out  1  ADC convert enable.
REQ-016 expose  out  1  exposure active.
REQ-017 erase  out  1  pixel erase active.
REQ-018 busy  out  1  controller is not in IDLE.
REQ-019 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-020 exp_time  out  EXP_W  current exposure setting.

Function
REQ-021 All outputs are registered: they change only on a clk edge and take the value of the state entered on that edge.
REQ-022 FSM states are IDLE, EXPOSE, READ, GAP and DONE.
REQ-023 IDLE outputs: erase=1, expose=0, adc=0, nre all 1, busy=0.
REQ-024 In IDLE, init=1 moves to EXPOSE and latches exp_time into an internal copy, exp_lat.
- init has priority over exp_inc and exp_dec.
REQ-025 In IDLE, init=0 with exp_inc=1 and exp_dec=0 adds 1 to exp_time, saturating at EXP_MAX.
REQ-026 In IDLE, init=0 with exp_dec=1 and exp_inc=0 subtracts 1 from exp_time, saturating at EXP_MIN.
- Both inputs high: no change.
REQ-027 exp_inc and exp_dec are ignored outside IDLE; exp_time is unchanged during a frame.
REQ-028 EXPOSE outputs: expose=1, erase=0, busy=1.
- EXPOSE lasts exactly exp_lat cycles, then moves to READ with row index 0.
REQ-029 READ outputs: adc=1, nre[row]=0, all other nre bits 1.
- READ lasts exactly ADC_CYCLES cycles, then moves to GAP.
- If GAP_CYCLES=0, READ moves instead to the next row's READ, or to DONE after the last row.
REQ-030 GAP outputs: adc=0, nre all 1, erase=0.
- GAP lasts GAP_CYCLES cycles.
- It then moves to READ with row+1, or to DONE if row = NUM_ROWS-1.
REQ-031 DONE lasts one cycle.
- Outputs: frame_done=1, erase=1, adc=0, expose=0, busy=1.
REQ-032 From DONE, continuous=1 moves to EXPOSE and re-latches the current exp_time; continuous=0 moves to IDLE.
REQ-033 frame_done is 0 in every state except DONE.
REQ-034 At most one nre bit is low at any time; adc=1 exactly when one nre bit is low.
REQ-035 Counters are sized for their maximum count (clog2) and never wrap during a frame.
REQ-036 init asserted while busy=1 has no effect.

Reset
REQ-037 reset=0 on a clk edge forces, on that edge, regardless of state:
- state=IDLE; nre all 1, adc=0, expose=0, erase=1, busy=0, frame_done=0;
- exp_time=EXP_RESET; all counters and the row index cleared.
REQ-038 A reset in the middle of a frame abandons the frame with no frame_done pulse.

Verification
REQ-039 Default parameters; init=1 for one cycle at edge 0:
- expose=1 on edges 1..15;
- adc=1 with nre=2'b10 on edges 16..20; gap at edge 21;
- nre=2'b01 on edges 22..26; gap at edge 27;
- frame_done=1 at edge 28; IDLE at edge 29.
REQ-040 exp_inc held 20 cycles from reset: exp_time=30 and holds; then exp_dec held 40 cycles: exp_time=2.
REQ-041 exp_inc=exp_dec=1 for 5 cycles in IDLE: exp_time stays at 15; the same presses during EXPOSE leave exp_time unchanged.
REQ-042 continuous=1 with NUM_ROWS=4, GAP_CYCLES=0, exp_time=2:
- expose=1 again on the cycle after each frame_done;
- frame period is 2+20+1 = 23 cycles;
- nre steps through 1110, 1101, 1011, 0111.
REQ-043 reset=0 at edge 18 during the row 0 read: on edge 18 nre=11, adc=0, erase=1, exp_time=15, busy=0, and no frame_done is seen.
REQ-044 Every test: assert that at most one nre bit is low and that adc equals "some nre bit is low".
